// File: rtl/alu24_arbiter.sv
// Round-robin arbiter sharing one ALU24 between two requesters; registers operands, captures result and flags.
// Latency: accept edge N -> RspValid visible in cycle N+2; at most one operation every 3 cycles.
// Backpressure: ReqReady only in IDLE; the response is held stable until RspReady of the granted requester.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu24_arbiter #(
    parameter int WIDTH = 24
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [1:0]       ReqValid,
    output logic [1:0]       ReqReady,
    input  logic [WIDTH-1:0] ReqA0,
    input  logic [WIDTH-1:0] ReqA1,
    input  logic [WIDTH-1:0] ReqB0,
    input  logic [WIDTH-1:0] ReqB1,
    input  logic [2:0]       ReqOp0,
    input  logic [2:0]       ReqOp1,
    output logic [1:0]       RspValid,
    input  logic [1:0]       RspReady,
    output logic [WIDTH-1:0] RspResult,
    output logic             RspZero,
    output logic             RspOverflow,
    output logic             RspCarryOut,
    output logic             RspError,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic [1:0]       AluOp,
    output logic             AluBNegate,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluZero,
    input  logic             AluOverflow,
    input  logic             AluCarryOut
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] OpCount0,
    output logic [CNT_W-1:0] OpCount1,
    output logic [CNT_W-1:0] ErrCount
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               alu_bneg_q, alu_bneg_d;
    logic [1:0]         rsp_vld_q, rsp_vld_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic               rsp_err_q, rsp_err_d;

    logic               gnt;
    logic               accept;
    logic               rsp_done;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [2:0]         sel_op;
    logic               op_legal;
    logic [1:0]         dec_op;
    logic               dec_bneg;

    // Pick the grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt = 1'b0;
        case (ReqValid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_gnt_q;
            default: gnt = 1'b0;
        endcase
        ReqReady = 2'b00;
        if (state_q == ST_IDLE && ReqValid != 2'b00) begin
            ReqReady = gnt ? 2'b10 : 2'b01;
        end
        accept   = |(ReqValid & ReqReady);
        rsp_done = (state_q == ST_RESP) && RspReady[last_gnt_q];
    end

    // Mux the granted requester's operands and decode its opcode into ALU24 controls.
    always_comb begin
        sel_a    = gnt ? ReqA1  : ReqA0;
        sel_b    = gnt ? ReqB1  : ReqB0;
        sel_op   = gnt ? ReqOp1 : ReqOp0;
        op_legal = 1'b1;
        dec_op   = 2'b00;
        dec_bneg = 1'b0;
        case (sel_op)
            3'b000:  dec_op = 2'b00;
            3'b001:  dec_op = 2'b01;
            3'b010:  dec_op = 2'b10;
            3'b011:  begin dec_op = 2'b10; dec_bneg = 1'b1; end
            3'b100:  dec_op = 2'b11;
            default: op_legal = 1'b0;
        endcase
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence and all registered outputs.
    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        illegal_d    = illegal_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_bneg_d   = alu_bneg_q;
        rsp_vld_d    = rsp_vld_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    last_gnt_d = gnt;
                    illegal_d  = ~op_legal;
                    // Illegal ops leave the ALU ports untouched; only the error is reported.
                    if (op_legal) begin
                        alu_a_d    = sel_a;
                        alu_b_d    = sel_b;
                        alu_op_d   = dec_op;
                        alu_bneg_d = dec_bneg;
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_vld_d = last_gnt_q ? 2'b10 : 2'b01;
                if (illegal_q) begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b0;
                    rsp_ovf_d    = 1'b0;
                    rsp_cout_d   = 1'b0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = AluResult;
                    rsp_zero_d   = AluZero;
                    rsp_ovf_d    = AluOverflow;
                    rsp_cout_d   = AluCarryOut;
                    rsp_err_d    = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_done) begin
                    rsp_vld_d = 2'b00;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= 1'b1;
            illegal_q    <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 2'b00;
            alu_bneg_q   <= 1'b0;
            rsp_vld_q    <= 2'b00;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            illegal_q    <= illegal_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_bneg_q   <= alu_bneg_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign AluA        = alu_a_q;
    assign AluB        = alu_b_q;
    assign AluOp       = alu_op_q;
    assign AluBNegate  = alu_bneg_q;
    assign RspValid    = rsp_vld_q;
    assign RspResult   = rsp_result_q;
    assign RspZero     = rsp_zero_q;
    assign RspOverflow = rsp_ovf_q;
    assign RspCarryOut = rsp_cout_q;
    assign RspError    = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] op_cnt0_q, op_cnt0_d;
    logic [CNT_W-1:0] op_cnt1_q, op_cnt1_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating counters: responses delivered per requester and illegal ops accepted.
    always_comb begin
        op_cnt0_d = op_cnt0_q;
        op_cnt1_d = op_cnt1_q;
        err_cnt_d = err_cnt_q;
        if (rsp_done && !last_gnt_q && op_cnt0_q != '1) op_cnt0_d = op_cnt0_q + 1'b1;
        if (rsp_done &&  last_gnt_q && op_cnt1_q != '1) op_cnt1_d = op_cnt1_q + 1'b1;
        if (accept && !op_legal && err_cnt_q != '1)     err_cnt_d = err_cnt_q + 1'b1;
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            op_cnt0_q <= '0;
            op_cnt1_q <= '0;
            err_cnt_q <= '0;
        end else begin
            op_cnt0_q <= op_cnt0_d;
            op_cnt1_q <= op_cnt1_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign OpCount0 = op_cnt0_q;
    assign OpCount1 = op_cnt1_q;
    assign ErrCount = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu24_arbiter.sv
// Directed bench for alu24_arbiter with a behavioural ALU24 stand-in.
// Vector table covers single-requester ops; hand sequences cover contention, backpressure and reset.
// Optional statistics ports are exercised when ALU_ARB_STATS_EN is defined.
module tb_alu24_arbiter;

    logic        Clock;
    logic        ResetN;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqReady;
    logic [23:0] ReqA0, ReqA1, ReqB0, ReqB1;
    logic [2:0]  ReqOp0, ReqOp1;
    logic [1:0]  RspValid;
    logic [1:0]  RspReady;
    logic [23:0] RspResult;
    logic        RspZero, RspOverflow, RspCarryOut, RspError;
    logic [23:0] AluA, AluB;
    logic [1:0]  AluOp;
    logic        AluBNegate;
    logic [23:0] AluResult;
    logic        AluZero, AluOverflow, AluCarryOut;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] OpCount0, OpCount1, ErrCount;
`endif

    int checks = 0;
    int errors = 0;

    alu24_arbiter dut (
        .Clock(Clock), .ResetN(ResetN),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
        .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
        .RspValid(RspValid), .RspReady(RspReady),
        .RspResult(RspResult), .RspZero(RspZero), .RspOverflow(RspOverflow),
        .RspCarryOut(RspCarryOut), .RspError(RspError),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluBNegate(AluBNegate),
        .AluResult(AluResult), .AluZero(AluZero), .AluOverflow(AluOverflow),
        .AluCarryOut(AluCarryOut)
`ifdef ALU_ARB_STATS_EN
        , .OpCount0(OpCount0), .OpCount1(OpCount1), .ErrCount(ErrCount)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Behavioural ALU24: AND/OR/ADD-SUB/XOR with carry and signed overflow on the adder path.
    logic [23:0] bx;
    logic [24:0] sum;
    always_comb begin
        bx          = AluBNegate ? ~AluB : AluB;
        sum         = {1'b0, AluA} + {1'b0, bx} + {24'd0, AluBNegate};
        AluResult   = 24'd0;
        AluCarryOut = 1'b0;
        AluOverflow = 1'b0;
        case (AluOp)
            2'b00: AluResult = AluA & AluB;
            2'b01: AluResult = AluA | AluB;
            2'b10: begin
                AluResult   = sum[23:0];
                AluCarryOut = sum[24];
                AluOverflow = (AluA[23] == bx[23]) && (sum[23] != AluA[23]);
            end
            default: AluResult = AluA ^ AluB;
        endcase
        AluZero = (AluResult == 24'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [23:0] a;
        logic [23:0] b;
        logic [2:0]  op;
        logic [23:0] res;
        logic        z;
        logic        o;
        logic        c;
        logic        e;
        logic [1:0]  aluop;
        logic        bneg;
    } vec_t;

    vec_t vt [11];

    // One isolated operation from a single requester, with cycle-exact latency checks.
    task automatic run_vec(input vec_t v);
        @(negedge Clock);
        if (v.req == 2'b01) begin
            ReqA0 = v.a; ReqB0 = v.b; ReqOp0 = v.op;
        end else begin
            ReqA1 = v.a; ReqB1 = v.b; ReqOp1 = v.op;
        end
        ReqValid = v.req;
        #1;
        chk("req_ready", {30'd0, ReqReady}, {30'd0, v.req});
        @(posedge Clock);
        #1 ReqValid = 2'b00;
        @(negedge Clock);
        chk("rsp_vld_n1", {30'd0, RspValid}, 32'd0);
        chk("alu_op", {30'd0, AluOp}, {30'd0, v.aluop});
        chk("alu_bneg", {31'd0, AluBNegate}, {31'd0, v.bneg});
        @(negedge Clock);
        chk("rsp_vld_n2", {30'd0, RspValid}, {30'd0, v.req});
        chk("rsp_result", {8'd0, RspResult}, {8'd0, v.res});
        chk("rsp_flags", {28'd0, RspZero, RspOverflow, RspCarryOut, RspError},
            {28'd0, v.z, v.o, v.c, v.e});
        RspReady = v.req;
        @(posedge Clock);
        #1 RspReady = 2'b00;
        @(negedge Clock);
        chk("rsp_vld_clr", {30'd0, RspValid}, 32'd0);
    endtask

    initial begin
        int n;
        logic [1:0] seen;
        //        req    a          b          op      res        z  o  c  e  aluop bneg
        vt[0]  = '{2'b01, 24'd10,    24'd20,    3'b010, 24'd30,    0, 0, 0, 0, 2'b10, 0};
        vt[1]  = '{2'b10, 24'd10,    24'd10,    3'b011, 24'd0,     1, 0, 1, 0, 2'b10, 1};
        vt[2]  = '{2'b01, 24'hF0F0F0, 24'h0FF0FF, 3'b000, 24'h00F0F0, 0, 0, 0, 0, 2'b00, 0};
        vt[3]  = '{2'b10, 24'h123456, 24'h00000F, 3'b001, 24'h12345F, 0, 0, 0, 0, 2'b01, 0};
        vt[4]  = '{2'b01, 24'hFFFFFF, 24'd1,     3'b010, 24'd0,     1, 0, 1, 0, 2'b10, 0};
        vt[5]  = '{2'b10, 24'h7FFFFF, 24'd1,     3'b010, 24'h800000, 0, 1, 0, 0, 2'b10, 0};
        vt[6]  = '{2'b01, 24'hAAAAAA, 24'h555555, 3'b100, 24'hFFFFFF, 0, 0, 0, 0, 2'b11, 0};
        vt[7]  = '{2'b01, 24'd5,     24'd7,     3'b011, 24'hFFFFFE, 0, 0, 0, 0, 2'b10, 1};
        vt[8]  = '{2'b01, 24'd1,     24'd2,     3'b110, 24'd0,     0, 0, 0, 1, 2'b10, 1};
        vt[9]  = '{2'b10, 24'd3,     24'd3,     3'b111, 24'd0,     0, 0, 0, 1, 2'b10, 1};
        vt[10] = '{2'b10, 24'd8,     24'd1,     3'b000, 24'd0,     1, 0, 0, 0, 2'b00, 0};

        ResetN = 1'b0; ReqValid = 2'b00; RspReady = 2'b00;
        ReqA0 = 24'd0; ReqA1 = 24'd0; ReqB0 = 24'd0; ReqB1 = 24'd0;
        ReqOp0 = 3'd0; ReqOp1 = 3'd0;
        #3;
        chk("reset_rsp", {RspValid, RspZero, RspOverflow, RspCarryOut, RspError, RspResult},
            32'd0);
        chk("reset_alu", {AluOp, AluBNegate, 5'd0, AluA}, 32'd0);
        chk("reset_aluB", {8'd0, AluB}, 32'd0);
        @(negedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        // Contention: both requesters always valid; last served was Req1 so Req0 goes first.
        @(negedge Clock);
        ReqA0 = 24'd6; ReqB0 = 24'd3; ReqOp0 = 3'b000;
        ReqA1 = 24'd6; ReqB1 = 24'd3; ReqOp1 = 3'b100;
        ReqValid = 2'b11; RspReady = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (RspValid == 2'b00 && n < 10) begin
                @(negedge Clock);
                n++;
            end
            chk("cont_timeout", {31'd0, (n >= 10)}, 32'd0);
            chk("cont_gnt", {30'd0, RspValid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_result", {8'd0, RspResult}, (k % 2 == 0) ? 32'd2 : 32'd5);
            if (k == 3) begin
                ReqValid = 2'b00;
            end
            @(negedge Clock);
        end
        RspReady = 2'b00;

        // Backpressure: response must hold while Req1 waits and the non-granted RspReady toggles.
        @(negedge Clock);
        ReqA0 = 24'd1; ReqB0 = 24'd2; ReqOp0 = 3'b010; ReqValid = 2'b01;
        @(posedge Clock);
        #1 ReqValid = 2'b10;
        @(negedge Clock);
        @(negedge Clock);
        RspReady = 2'b10;
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", {30'd0, RspValid}, 32'd1);
            chk("bp_result", {8'd0, RspResult}, 32'd3);
            chk("bp_ready", {30'd0, ReqReady}, 32'd0);
            @(negedge Clock);
        end
        ReqValid = 2'b00; RspReady = 2'b01;
        @(negedge Clock);
        RspReady = 2'b00;
        chk("bp_release", {30'd0, RspValid}, 32'd0);

`ifdef ALU_ARB_STATS_EN
        chk("op_count0", {16'd0, OpCount0}, 32'd9);
        chk("op_count1", {16'd0, OpCount1}, 32'd7);
        chk("err_count", {16'd0, ErrCount}, 32'd2);
`endif

        // Reset while the operation sits in EXEC.
        @(negedge Clock);
        ReqA1 = 24'd4; ReqB1 = 24'd4; ReqOp1 = 3'b010; ReqValid = 2'b10; RspReady = 2'b11;
        @(posedge Clock);
        #1 ReqValid = 2'b00;
        #2 ResetN = 1'b0;
        #1;
        chk("rst_exec_rsp", {RspValid, RspZero, RspOverflow, RspCarryOut, RspError, RspResult},
            32'd0);
        chk("rst_exec_alu", {AluOp, AluBNegate, 5'd0, AluA}, 32'd0);
        chk("rst_exec_rdy", {30'd0, ReqReady}, 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_counts", {OpCount0, ErrCount}, 32'd0);
`endif
        @(negedge Clock);
        ResetN = 1'b1;
        seen = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            seen = seen | RspValid;
        end
        chk("no_stale_rsp", {30'd0, seen}, 32'd0);
        RspReady = 2'b00;

        ReqA0 = 24'd6; ReqB0 = 24'd3; ReqOp0 = 3'b000;
        ReqA1 = 24'd6; ReqB1 = 24'd3; ReqOp1 = 3'b100;
        ReqValid = 2'b11;
        #1;
        chk("post_rst_tie", {30'd0, ReqReady}, 32'd1);
        @(posedge Clock);
        #1 ReqValid = 2'b00;
        @(negedge Clock);
        @(negedge Clock);
        chk("post_rst_vld", {30'd0, RspValid}, 32'd1);
        chk("post_rst_res", {8'd0, RspResult}, 32'd2);
        RspReady = 2'b01;
        @(negedge Clock);
        RspReady = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
